// File: rtl/spi_master_sequencer_if.sv
// Valid/ready streams between protocol logic and the SPI sequencer.
// slave: sequencer side; master: producer/consumer side.
interface spi_master_sequencer_if #(
  parameter int NUM_DATA_BITS = 8
);
  logic                     tx_valid;
  logic                     tx_ready;
  logic [NUM_DATA_BITS-1:0] tx_data;
  logic                     tx_last;
  logic                     rx_valid;
  logic                     rx_ready;
  logic [NUM_DATA_BITS-1:0] rx_data;
  logic                     rx_last;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready,
    input  rx_valid, rx_data, rx_last,
    output rx_ready
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready,
    output rx_valid, rx_data, rx_last,
    input  rx_ready
  );
endinterface

// File: rtl/spi_master_sequencer.sv
// One-in-flight SPI transaction sequencer with RX FIFO and last tagging.
// Optional watchdog on the driver response: define SPI_SEQ_TIMEOUT_EN.
module spi_master_sequencer #(
  parameter int NUM_DATA_BITS  = 8,
  parameter int RX_FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  spi_master_sequencer_if.slave    s_if,
  output logic                     busy,
  output logic                     timeout_err,
  output logic                     drv_comm_start,
  output logic [NUM_DATA_BITS-1:0] drv_mosi_data,
  input  logic                     drv_bus_ready,
  input  logic                     drv_miso_new_data,
  input  logic [NUM_DATA_BITS-1:0] drv_miso_data
);
  localparam int AW = $clog2(RX_FIFO_DEPTH);

  if (RX_FIFO_DEPTH < 2 ||
      (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("spi_master_sequencer: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE, START, WAIT_DATA, WAIT_READY
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nx;
  logic [NUM_DATA_BITS:0]   r_mem [RX_FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [AW:0]              r_count;
  logic                     r_last_q;
  logic                     r_busy;
  logic [NUM_DATA_BITS-1:0] r_mosi;
  logic                     w_full;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_done;
  logic                     w_tmo;

  assign w_full = r_count == (AW+1)'(RX_FIFO_DEPTH);

  // Gated by rst_n so the stream looks idle while reset is held.
  assign s_if.tx_ready = rst_n && (r_state == IDLE)
                      && drv_bus_ready && !w_full;
  assign s_if.rx_valid = r_count != '0;
  assign {s_if.rx_last, s_if.rx_data} =
    s_if.rx_valid ? r_mem[r_rd_ptr] : '0;
  assign w_pop = s_if.rx_valid && s_if.rx_ready;

  assign drv_comm_start = r_state == START;
  assign drv_mosi_data  = r_mosi;
  assign busy           = r_busy;

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_push     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_if.tx_valid && s_if.tx_ready) begin
          w_accept   = 1'b1;
          w_state_nx = START;
        end
      end
      START: w_state_nx = WAIT_DATA;
      WAIT_DATA: begin
        if (drv_miso_new_data) begin
          w_push     = 1'b1;
          w_state_nx = WAIT_READY;
        end else if (w_tmo) begin
          w_state_nx = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (drv_bus_ready) begin
          w_done     = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_last_q <= 1'b0;
      r_mosi   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_mosi   <= s_if.tx_data;
        r_last_q <= s_if.tx_last;
        r_busy   <= 1'b1;
      end else if (w_done || w_tmo) begin
        r_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {r_last_q, drv_miso_data};
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tcnt;
  logic          r_tmo_err;

  // Fires on the cycle the count would reach the limit.
  assign w_tmo = (r_state == WAIT_DATA) && !drv_miso_new_data
              && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_tmo_err;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt    <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (w_accept)
        r_tcnt <= '0;
      else if (r_state == START || r_state == WAIT_DATA)
        r_tcnt <= r_tcnt + TW'(1);
      if (w_accept)
        r_tmo_err <= 1'b0;
      else if (w_tmo)
        r_tmo_err <= 1'b1;
    end
  end
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Scoreboard bench for spi_master_sequencer with a simple driver model.
// Build with SPI_SEQ_TIMEOUT_EN to exercise the watchdog path.
module tb_spi_master_sequencer;
  localparam int N  = 8;
  localparam int D  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_sequencer_if #(.NUM_DATA_BITS(N)) ifc();

  logic         busy;
  logic         timeout_err;
  logic         drv_comm_start;
  logic [N-1:0] drv_mosi_data;
  logic         drv_bus_ready;
  logic         drv_miso_new_data;
  logic [N-1:0] drv_miso_data;
  logic         tb_rx_ready;
  logic         mdl_pop;

  assign ifc.rx_ready = tb_rx_ready | mdl_pop;

  spi_master_sequencer #(
    .NUM_DATA_BITS (N),
    .RX_FIFO_DEPTH (D),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk          (clk),
    .rst_n            (rst_n),
    .s_if             (ifc),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .drv_comm_start   (drv_comm_start),
    .drv_mosi_data    (drv_mosi_data),
    .drv_bus_ready    (drv_bus_ready),
    .drv_miso_new_data(drv_miso_new_data),
    .drv_miso_data    (drv_miso_data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;
  logic [N:0] exp_q[$];

  bit           hang = 1'b0;
  bit           use_fixed = 1'b0;
  logic [N-1:0] fixed_resp = '0;
  bit           pop_on_nd = 1'b0;
  logic [N-1:0] mosi_seen = '0;
  int           start_cyc = 0;
  int           nd_cyc = 0;
  int           acc_cyc = 0;
  int           rv_cyc = 0;
  int           npulse = 0;
  int           naccept = 0;
  int           npop = 0;
  bit           prev_start = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Driver model: echoes MOSI or returns a fixed word.
  initial begin
    drv_bus_ready     = 1'b1;
    drv_miso_new_data = 1'b0;
    drv_miso_data     = '0;
    mdl_pop           = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && drv_comm_start) begin
        mosi_seen = drv_mosi_data;
        @(posedge clk);
        #2 drv_bus_ready = 1'b0;
        if (hang) begin
          while (hang) @(posedge clk);
          #2 drv_bus_ready = 1'b1;
        end else begin
          repeat (2) @(posedge clk);
          #2;
          drv_miso_new_data = 1'b1;
          drv_miso_data = use_fixed ? fixed_resp : mosi_seen;
          nd_cyc = cyc;
          mdl_pop = pop_on_nd;
          @(posedge clk);
          #2;
          drv_miso_new_data = 1'b0;
          mdl_pop = 1'b0;
          repeat (2) @(posedge clk);
          #2 drv_bus_ready = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (drv_comm_start) begin
      chk("start_one_cycle", 32'(prev_start), 0);
      npulse++;
      start_cyc = cyc;
    end
    prev_start = drv_comm_start;
  end

  // Monitor: pops the scoreboard whenever a word is handed over.
  always @(negedge clk) begin
    if (rst_n && ifc.rx_valid && ifc.rx_ready) begin
      npop++;
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL rx_unexpected: got %0h, expected none",
                 {ifc.rx_last, ifc.rx_data});
      end else begin
        chk("rx_word", 32'({ifc.rx_last, ifc.rx_data}),
            32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] d, input logic l,
                      input logic [N-1:0] r, input bit push);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clk);
    #1;
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = d;
    ifc.tx_last  = l;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (ifc.tx_ready) ok = 1'b1;
      else n++;
    end
    chk("tx_accept", 32'(ok), 1);
    if (ok) begin
      acc_cyc = cyc;
      naccept++;
      if (push) exp_q.push_back({l, r});
    end
    @(posedge clk);
    #1 ifc.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      if (!busy && drv_bus_ready) ok = 1'b1;
      else n++;
    end
    chk("wait_idle", 32'(ok), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ifc.rx_valid) ok = 1'b1;
      else n++;
    end
    chk("wait_drain", 32'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int np0;
    int seen;
    int n;
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = '0;
    ifc.tx_last  = 1'b0;
    tb_rx_ready  = 1'b0;

    // Reset state
    tick(3);
    chk("rst_tx_ready", 32'(ifc.tx_ready), 0);
    chk("rst_rx_valid", 32'(ifc.rx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_comm_start", 32'(drv_comm_start), 0);
    chk("rst_mosi", 32'(drv_mosi_data), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_tx_ready", 32'(ifc.tx_ready), 1);

    // Single word with fixed response
    use_fixed  = 1'b1;
    fixed_resp = 8'h3C;
    p0 = npulse;
    send(8'hA5, 1'b1, 8'h3C, 1'b1);
    n = 0;
    while (!ifc.rx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    rv_cyc = cyc;
    chk("rx_valid_seen", 32'(ifc.rx_valid), 1);
    chk("start_latency", 32'(start_cyc), 32'(acc_cyc + 1));
    chk("mosi_data", 32'(drv_mosi_data), 32'h0A5);
    chk("mosi_at_driver", 32'(mosi_seen), 32'h0A5);
    chk("rx_latency", 32'(rv_cyc), 32'(nd_cyc + 1));
    chk("busy_in_flight", 32'(busy), 1);
    wait_idle(20);
    chk("single_pulses", 32'(npulse - p0), 1);
    tb_rx_ready = 1'b1;
    wait_drain(20);
    tb_rx_ready = 1'b0;
    use_fixed = 1'b0;

    // Three-word frame, echo, consumer always ready
    tb_rx_ready = 1'b1;
    p0 = npulse;
    send(8'h01, 1'b0, 8'h01, 1'b1);
    send(8'h02, 1'b0, 8'h02, 1'b1);
    send(8'h03, 1'b1, 8'h03, 1'b1);
    wait_drain(60);
    wait_idle(20);
    chk("frame_pulses", 32'(npulse - p0), 3);
    tb_rx_ready = 1'b0;

    // Backpressure: FIFO fills at four words
    p0 = npulse;
    for (int i = 0; i < 4; i++)
      send(N'(8'h10 + i), 1'b0, N'(8'h10 + i), 1'b1);
    wait_idle(20);
    chk("bp_pulses4", 32'(npulse - p0), 4);
    @(posedge clk);
    #1;
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = 8'h14;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifc.tx_ready) seen++;
    end
    ifc.tx_valid = 1'b0;
    chk("bp_tx_ready_low", 32'(seen), 0);
    chk("bp_no_issue", 32'(npulse - p0), 4);
    tick(1);
    tb_rx_ready = 1'b1;
    tick(1);
    tb_rx_ready = 1'b0;
    send(8'h14, 1'b0, 8'h14, 1'b1);
    wait_idle(20);
    chk("bp_pulses5", 32'(npulse - p0), 5);
    tb_rx_ready = 1'b1;
    wait_drain(40);
    send(8'h15, 1'b1, 8'h15, 1'b1);
    wait_drain(40);
    wait_idle(20);
    tb_rx_ready = 1'b0;
    chk("bp_pulses6", 32'(npulse - p0), 6);

    // Push and pop in the same cycle with three stored, across a wrap
    for (int i = 0; i < 3; i++)
      send(N'(8'h20 + i), 1'b0, N'(8'h20 + i), 1'b1);
    wait_idle(20);
    for (int k = 0; k < 5; k++) begin
      pop_on_nd = 1'b1;
      send(N'(8'h23 + k), k[0], N'(8'h23 + k), 1'b1);
      wait_idle(20);
      pop_on_nd = 1'b0;
      chk("sim_not_full", 32'(ifc.tx_ready), 1);
    end
    np0 = npop;
    tb_rx_ready = 1'b1;
    wait_drain(20);
    tb_rx_ready = 1'b0;
    chk("sim_drain_3", 32'(npop - np0), 3);

    // Reset while waiting for driver data
    send(8'h30, 1'b0, 8'h30, 1'b1);
    wait_idle(20);
    hang = 1'b1;
    send(8'h31, 1'b1, 8'h00, 1'b0);
`ifdef SPI_SEQ_TIMEOUT_EN
    tick(5);
`else
    tick(40);
    chk("no_timeout", 32'(timeout_err), 0);
`endif
    chk("hang_busy", 32'(busy), 1);
    chk("pre_rst_rx_valid", 32'(ifc.rx_valid), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tx_ready", 32'(ifc.tx_ready), 0);
    chk("arst_rx_valid", 32'(ifc.rx_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_comm_start", 32'(drv_comm_start), 0);
    chk("arst_mosi", 32'(drv_mosi_data), 0);
    chk("arst_rx_data", 32'({ifc.rx_last, ifc.rx_data}), 0);
    chk("arst_timeout", 32'(timeout_err), 0);
    exp_q.delete();
    hang = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_rx_valid", 32'(ifc.rx_valid), 0);
    tb_rx_ready = 1'b1;
    send(8'h42, 1'b1, 8'h42, 1'b1);
    wait_drain(40);
    wait_idle(20);
    tb_rx_ready = 1'b0;

`ifdef SPI_SEQ_TIMEOUT_EN
    // Watchdog: driver never answers
    hang = 1'b1;
    send(8'h50, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (!timeout_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycle", 32'(cyc), 32'(start_cyc + TO));
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_rx_empty", 32'(ifc.rx_valid), 0);
    hang = 1'b0;
    wait_idle(20);
    tb_rx_ready = 1'b1;
    send(8'h51, 1'b1, 8'h51, 1'b1);
    chk("tmo_cleared", 32'(timeout_err), 0);
    wait_drain(40);
    wait_idle(20);
    tb_rx_ready = 1'b0;
`endif

    chk("pulses_vs_accepts", 32'(npulse), 32'(naccept));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
